mem_access_unit: RTL

Stage-4 load/store unit between execute and writeback. Takes one load or store per instruction from the EX/MEM register, issues it to the data cache over a valid/ready request and valid response channel, and formats returned load data. It also drives the data-miss stall and produces the `read_data` word that writeback selects when `data_sel[0]` is set. Only one request is outstanding at any time.

---
 rtl/mem_access_unit_pkg.sv | 30 +++
 rtl/mem_access_unit_if.sv | 21 ++
 rtl/mem_access_unit_align.sv | 53 +++++
 rtl/mem_access_unit.sv | 139 +++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the load/store unit and its data-cache channel.
package mem_access_unit_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'b00,
    LSU_REQ  = 2'b01,
    LSU_WAIT = 2'b10,
    LSU_DONE = 2'b11
  } lsu_state_e;

  typedef struct packed {
    logic            valid;
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [3:0]      wstrb;
  } dreq_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] data;
  } dres_t;

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-cache request/response channel between the LSU (master) and the cache (slave).
interface mem_access_unit_if;
  import mem_access_unit_pkg::*;

  dreq_t dreq;
  logic  dreq_ready;
  dres_t dres;

  modport master (
    output dreq,
    input  dreq_ready,
    input  dres
  );

  modport slave (
    input  dreq,
    output dreq_ready,
    output dres
  );

endinterface

// File: rtl/mem_access_unit_align.sv
// Combinational lane logic: store strobes/replication, misalignment and load extraction.
module mem_access_unit_align
  import mem_access_unit_pkg::*;
(
  input  logic [1:0]      req_off_i,
  input  logic [1:0]      req_size_i,
  input  logic [XLEN-1:0] req_wdata_i,
  output logic [3:0]      req_wstrb_o,
  output logic [XLEN-1:0] req_wdata_o,
  output logic            req_misalign_o,
  input  logic [1:0]      rsp_off_i,
  input  logic [1:0]      rsp_size_i,
  input  logic            rsp_unsigned_i,
  input  logic [XLEN-1:0] rsp_raw_i,
  output logic [XLEN-1:0] rsp_data_o
);

  logic [XLEN-1:0] rsp_shift;

  always_comb begin
    req_wstrb_o    = 4'b1111;
    req_wdata_o    = req_wdata_i;
    req_misalign_o = 1'b0;
    case (req_size_i)
      SZ_BYTE: begin
        req_wstrb_o = 4'b0001 << req_off_i;
        req_wdata_o = {4{req_wdata_i[7:0]}};
      end
      SZ_HALF: begin
        req_wstrb_o    = 4'b0011 << req_off_i;
        req_wdata_o    = {2{req_wdata_i[15:0]}};
        req_misalign_o = req_off_i[0];
      end
      // Reserved size 11 behaves as a word access.
      default: begin
        req_misalign_o = (req_off_i != 2'b00);
      end
    endcase
  end

  always_comb begin
    rsp_shift  = rsp_raw_i >> {rsp_off_i, 3'b000};
    rsp_data_o = rsp_shift;
    case (rsp_size_i)
      SZ_BYTE: rsp_data_o = rsp_unsigned_i ? {24'h0, rsp_shift[7:0]}
                                           : {{24{rsp_shift[7]}}, rsp_shift[7:0]};
      SZ_HALF: rsp_data_o = rsp_unsigned_i ? {16'h0, rsp_shift[15:0]}
                                           : {{16{rsp_shift[15]}}, rsp_shift[15:0]};
      default: rsp_data_o = rsp_shift;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: one outstanding data-cache access, data-miss stall and load formatting.
module mem_access_unit
  import mem_access_unit_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                ld_en_i,
  input  logic                st_en_i,
  input  logic [1:0]          rw_size_i,
  input  logic                ld_unsigned_i,
  input  logic [XLEN-1:0]     addr_i,
  input  logic [XLEN-1:0]     wdata_i,
  input  logic                flush_i,
  mem_access_unit_if.master   dbus,
  output logic [XLEN-1:0]     read_data_o,
  output logic                dmiss_stall_o,
  output logic                ld_misalign_o,
  output logic                st_misalign_o
);

  lsu_state_e      state_q, state_d;
  logic            kill_q, kill_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [1:0]      size_q, size_d;
  logic            uns_q, uns_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [3:0]      wstrb_q, wstrb_d;
  logic [XLEN-1:0] read_data_q, read_data_d;

  logic [3:0]      al_wstrb;
  logic [XLEN-1:0] al_wdata;
  logic            al_misalign;
  logic [XLEN-1:0] al_rdata;
  logic            acc_ok;
  logic            stall;

  // Request side sees the live instruction; response side sees the latched access.
  mem_access_unit_align u_align (
    .req_off_i      (addr_i[1:0]),
    .req_size_i     (rw_size_i),
    .req_wdata_i    (wdata_i),
    .req_wstrb_o    (al_wstrb),
    .req_wdata_o    (al_wdata),
    .req_misalign_o (al_misalign),
    .rsp_off_i      (addr_q[1:0]),
    .rsp_size_i     (size_q),
    .rsp_unsigned_i (uns_q),
    .rsp_raw_i      (dbus.dres.data),
    .rsp_data_o     (al_rdata)
  );

  assign ld_misalign_o = ld_en_i & al_misalign;
  assign st_misalign_o = st_en_i & al_misalign;
  assign acc_ok        = (ld_en_i | st_en_i) & ~al_misalign & ~flush_i;

  always_comb begin
    state_d     = state_q;
    kill_d      = kill_q;
    addr_d      = addr_q;
    size_d      = size_q;
    uns_d       = uns_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    read_data_d = read_data_q;
    stall       = 1'b0;
    case (state_q)
      LSU_IDLE: begin
        kill_d = 1'b0;
        if (acc_ok) begin
          stall   = 1'b1;
          addr_d  = addr_i;
          size_d  = rw_size_i;
          uns_d   = ld_unsigned_i;
          we_d    = st_en_i;
          wdata_d = al_wdata;
          wstrb_d = st_en_i ? al_wstrb : 4'b0000;
          state_d = LSU_REQ;
        end
      end
      LSU_REQ: begin
        stall = 1'b1;
        if (flush_i) kill_d = 1'b1;
        if (dbus.dreq_ready) state_d = LSU_WAIT;
      end
      LSU_WAIT: begin
        stall = 1'b1;
        if (flush_i) kill_d = 1'b1;
        // A flush coinciding with the response still kills the access.
        if (dbus.dres.valid) begin
          if (kill_q | flush_i) begin
            state_d = LSU_IDLE;
          end else begin
            if (!we_q) read_data_d = al_rdata;
            state_d = LSU_DONE;
          end
        end
      end
      default: begin
        state_d = LSU_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= LSU_IDLE;
      kill_q      <= 1'b0;
      addr_q      <= '0;
      size_q      <= SZ_BYTE;
      uns_q       <= 1'b0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      wstrb_q     <= 4'b0000;
      read_data_q <= '0;
    end else begin
      state_q     <= state_d;
      kill_q      <= kill_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      read_data_q <= read_data_d;
    end
  end

  assign dbus.dreq.valid = (state_q == LSU_REQ);
  assign dbus.dreq.we    = we_q;
  assign dbus.dreq.addr  = {addr_q[XLEN-1:2], 2'b00};
  assign dbus.dreq.wdata = wdata_q;
  assign dbus.dreq.wstrb = wstrb_q;

  assign read_data_o   = read_data_q;
  assign dmiss_stall_o = stall;

endmodule
